// File: rtl/filtro_biquad_mac_if.sv
// Sample/coefficient/result bundle for the biquad MAC.
// The master drives sample and coefficients; the slave returns the result and status.
interface filtro_biquad_mac_if #(
    parameter int unsigned N = 25
) ();
    logic                Start;
    logic signed [N-1:0] Xk;
    logic signed [N-1:0] b0;
    logic signed [N-1:0] b1;
    logic signed [N-1:0] b2;
    logic signed [N-1:0] a1;
    logic signed [N-1:0] a2;
    logic signed [N-1:0] Yk_out;
    logic                Finish;
    logic                Busy;

    modport master (
        output Start, Xk, b0, b1, b2, a1, a2,
        input  Yk_out, Finish, Busy
    );

    modport slave (
        input  Start, Xk, b0, b1, b2, a1, a2,
        output Yk_out, Finish, Busy
    );
endinterface

// File: rtl/filtro_biquad_mac.sv
// Sequential fixed-point biquad: one shared multiplier-accumulator, five MAC steps per sample,
// then scale by 2^-F with floor and saturate to N bits.
module filtro_biquad_mac #(
    parameter int unsigned N = 25,
    parameter int unsigned F = 12
) (
    input  logic                clk,
    input  logic                reset,
    filtro_biquad_mac_if.slave  bus
);
    localparam int unsigned AccW = 2 * N + 3;

    typedef enum logic [1:0] {StIdle, StMac, StSat, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [2:0]             r_step;
    logic signed [N-1:0]    r_x0;
    logic signed [N-1:0]    r_x1;
    logic signed [N-1:0]    r_x2;
    logic signed [N-1:0]    r_y1;
    logic signed [N-1:0]    r_y2;
    logic signed [N-1:0]    r_yk;
    logic signed [AccW-1:0] r_acc;

    logic signed [N-1:0]    w_coef;
    logic signed [N-1:0]    w_data;
    logic signed [2*N-1:0]  w_prod;
    logic signed [AccW-1:0] w_prod_ext;
    logic signed [AccW-1:0] w_scaled;
    logic signed [N-1:0]    w_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.Start) w_state_next = StMac;
            StMac:   if (r_step == 3'd4) w_state_next = StSat;
            StSat:   w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.Yk_out = r_yk;
        bus.Finish = (r_state == StDone);
        bus.Busy   = (r_state != StIdle);
    end

    always_comb begin
        w_coef = bus.b0;
        w_data = r_x0;
        case (r_step)
            3'd1: begin w_coef = bus.b1; w_data = r_x1; end
            3'd2: begin w_coef = bus.b2; w_data = r_x2; end
            3'd3: begin w_coef = bus.a1; w_data = r_y1; end
            3'd4: begin w_coef = bus.a2; w_data = r_y2; end
            default: ;
        endcase
    end

    assign w_prod     = $signed({{N{w_coef[N-1]}}, w_coef}) * $signed({{N{w_data[N-1]}}, w_data});
    assign w_prod_ext = {{3{w_prod[2*N-1]}}, w_prod};
    assign w_scaled   = r_acc >>> F;

    // In range only when every bit from N-1 upward equals the sign bit.
    always_comb begin
        if (!w_scaled[AccW-1] && (|w_scaled[AccW-2:N-1])) begin
            w_sat = {1'b0, {(N-1){1'b1}}};
        end else if (w_scaled[AccW-1] && !(&w_scaled[AccW-2:N-1])) begin
            w_sat = {1'b1, {(N-1){1'b0}}};
        end else begin
            w_sat = w_scaled[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step <= '0;
            r_acc  <= '0;
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_y1   <= '0;
            r_y2   <= '0;
            r_yk   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.Start) begin
                        r_x0   <= bus.Xk;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                StMac: begin
                    // Feedback terms (steps 3 and 4) are subtracted.
                    if (r_step < 3'd3) begin
                        r_acc <= r_acc + w_prod_ext;
                    end else begin
                        r_acc <= r_acc - w_prod_ext;
                    end
                    r_step <= r_step + 3'd1;
                end
                StSat: begin
                    r_yk <= w_sat;
                    r_x2 <= r_x1;
                    r_x1 <= r_x0;
                    r_y2 <= r_y1;
                    r_y1 <= w_sat;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_filtro_biquad_mac.sv
// Self-checking bench for filtro_biquad_mac: directed vector table, hand-written timing
// sequences, and random samples against an arithmetic reference model.
module tb_filtro_biquad_mac;
    localparam int N = 25;
    localparam int F = 12;
    localparam longint YMax = 16777215;
    localparam longint YMin = -16777216;

    logic clk = 1'b0;
    logic reset = 1'b0;

    filtro_biquad_mac_if #(.N(N)) bus ();

    filtro_biquad_mac #(.N(N), .F(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint m_b0, m_b1, m_b2, m_a1, m_a2;
    longint m_x1, m_x2, m_y1, m_y2;

    typedef struct {
        bit     rst;
        longint b0, b1, b2, a1, a2;
        longint x;
        longint y;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_coef(input longint b0, input longint b1, input longint b2,
                            input longint a1, input longint a2);
        m_b0 = b0; m_b1 = b1; m_b2 = b2; m_a1 = a1; m_a2 = a2;
        bus.b0 = N'(b0);
        bus.b1 = N'(b1);
        bus.b2 = N'(b2);
        bus.a1 = N'(a1);
        bus.a2 = N'(a2);
    endtask

    function automatic void clear_model();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endfunction

    // y = floor((b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^F), clamped to N bits.
    function automatic longint model_step(input longint x);
        longint acc;
        longint y;
        acc = m_b0 * x + m_b1 * m_x1 + m_b2 * m_x2 - m_a1 * m_y1 - m_a2 * m_y2;
        y = acc >>> F;
        if (y > YMax) y = YMax;
        if (y < YMin) y = YMin;
        m_x2 = m_x1; m_x1 = x;
        m_y2 = m_y1; m_y1 = y;
        return y;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.Start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    // Issues one Start and watches 12 cycles; Xk is scrambled after acceptance.
    task automatic run_sample(input longint x, output longint y, output int lat,
                              output int busy_n, output int fin_n);
        @(negedge clk);
        bus.Xk = N'(x);
        bus.Start = 1'b1;
        lat = 0; busy_n = 0; fin_n = 0; y = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.Start = 1'b0;
            if (k == 1) bus.Xk = N'($urandom);
            if (bus.Busy) busy_n++;
            if (bus.Finish) begin
                fin_n++;
                if (lat == 0) begin
                    lat = k;
                    y = longint'(bus.Yk_out);
                end
            end
        end
        chk("hold", longint'(bus.Yk_out), y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        longint y;
        longint x;
        int lat, busy_n, fin_n;

        tbl[0]  = '{1'b1, 4096, 0, 0, 0, 0, 1000, 1000};
        tbl[1]  = '{1'b1, 4096, 2048, 1024, 0, 0, 4096, 4096};
        tbl[2]  = '{1'b0, 4096, 2048, 1024, 0, 0, 0, 2048};
        tbl[3]  = '{1'b0, 4096, 2048, 1024, 0, 0, 0, 1024};
        tbl[4]  = '{1'b0, 4096, 2048, 1024, 0, 0, 0, 0};
        tbl[5]  = '{1'b1, 4096, 0, 0, -2048, 0, 4096, 4096};
        tbl[6]  = '{1'b0, 4096, 0, 0, -2048, 0, 0, 2048};
        tbl[7]  = '{1'b0, 4096, 0, 0, -2048, 0, 0, 1024};
        tbl[8]  = '{1'b1, 8192, 0, 0, 0, 0, 16777215, 16777215};
        tbl[9]  = '{1'b0, 8192, 0, 0, 0, 0, -16777216, -16777216};
        tbl[10] = '{1'b1, 2048, 0, 0, 0, 0, -3, -2};
        tbl[11] = '{1'b0, 2048, 0, 0, 0, 0, 3, 1};

        bus.Start = 1'b0;
        bus.Xk = '0;
        set_coef(0, 0, 0, 0, 0);
        clear_model();
        #12;
        chk("reset Yk_out", longint'(bus.Yk_out), 0);
        chk("reset Finish", longint'(bus.Finish), 0);
        chk("reset Busy", longint'(bus.Busy), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            set_coef(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].a1, tbl[i].a2);
            run_sample(tbl[i].x, y, lat, busy_n, fin_n);
            chk($sformatf("vec%0d y", i), y, tbl[i].y);
            chk($sformatf("vec%0d latency", i), lat, 7);
            chk($sformatf("vec%0d busy", i), busy_n, 7);
            chk($sformatf("vec%0d finish", i), fin_n, 1);
        end

        // Start during MAC and during DONE must both be ignored.
        do_reset();
        set_coef(4096, 0, 0, 0, 0);
        @(negedge clk);
        bus.Xk = N'(500);
        bus.Start = 1'b1;
        busy_n = 0; fin_n = 0; y = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.Busy) busy_n++;
            if (bus.Finish) begin
                fin_n++;
                y = longint'(bus.Yk_out);
            end
            bus.Start = (k == 3 || k == 7);
        end
        chk("busy-start finish", fin_n, 1);
        chk("busy-start busy", busy_n, 7);
        chk("busy-start y", y, 500);

        // Start held high: one accept every 8 cycles.
        @(negedge clk);
        bus.Xk = N'(300);
        bus.Start = 1'b1;
        fin_n = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (bus.Finish) fin_n++;
        end
        bus.Start = 1'b0;
        chk("held-start finishes", fin_n, 3);
        chk("held-start y", longint'(bus.Yk_out), 300);

        // Reset during MAC step 2 of the second sample.
        do_reset();
        set_coef(4096, 4096, 0, 0, 0);
        run_sample(100, y, lat, busy_n, fin_n);
        chk("midreset first y", y, 100);
        @(negedge clk);
        bus.Xk = N'(7);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset Yk_out", longint'(bus.Yk_out), 0);
        chk("midreset Finish", longint'(bus.Finish), 0);
        chk("midreset Busy", longint'(bus.Busy), 0);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        run_sample(0, y, lat, busy_n, fin_n);
        chk("midreset history", y, 0);
        chk("midreset finish", fin_n, 1);

        // Random coefficients and samples against the reference model.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_coef(longint'($urandom_range(0, 16383)) - 8192,
                     longint'($urandom_range(0, 16383)) - 8192,
                     longint'($urandom_range(0, 16383)) - 8192,
                     longint'($urandom_range(0, 8191)) - 4096,
                     longint'($urandom_range(0, 4095)) - 2048);
            for (int s = 0; s < 8; s++) begin
                x = longint'($urandom_range(0, 33554431)) - 16777216;
                if (s % 3 == 2) x = x >>> 12;
                run_sample(x, y, lat, busy_n, fin_n);
                chk($sformatf("rand b%0d s%0d y", b, s), y, model_step(x));
                chk($sformatf("rand b%0d s%0d latency", b, s), lat, 7);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
